stack_tos_sequencer: RTL and testbench

- Command-level controller for the stack/TOS datapath block.
- Accepts one stack command at a time through a valid/ready handshake and drives that block's control strobes in a fixed per-command cycle sequence.
- Checks for stack overflow and underflow, and reports completion with a done pulse.
- Sits between the instruction decoder and the stack/TOS datapath.

---
 rtl/stack_tos_sequencer.sv | 168 ++++++++++++++++
 tb/tb_stack_tos_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_tos_sequencer.sv
// Stack/TOS command sequencer: one command per handshake,
// fixed strobe sequence per op, overflow/underflow detection.
module stack_tos_sequencer #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic [2:0]            cmd_op,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] tos_cur,
  input  logic                  err_clr,
  output logic [2:0]            SEL_MUX_STACK,
  output logic                  CTRL_REG_READ_STACK,
  output logic                  CTRL_REG_WRITE_STACK,
  output logic                  CTRL_REG_READ_MEM,
  output logic                  CTRL_REG_WRITE_MEM,
  output logic                  SEL_MUX_TOS,
  output logic                  CTRL_REG_TOS,
  output logic                  SEL_TOS_UPDATER,
  output logic                  CTRL_STACK,
  output logic                  CTRL_MEM_EXT,
  output logic                  done,
  output logic                  done_err,
  output logic                  ovf_flag,
  output logic                  unf_flag,
  output logic [15:0]           op_count
);

  localparam logic [2:0] OP_PUSH_ALU = 3'd0;
  localparam logic [2:0] OP_LOAD     = 3'd1;
  localparam logic [2:0] OP_PUSH_RET = 3'd2;
  localparam logic [2:0] OP_PUSH_ARG = 3'd3;
  localparam logic [2:0] OP_DUP      = 3'd4;
  localparam logic [2:0] OP_POP      = 3'd5;
  localparam logic [2:0] OP_STORE    = 3'd6;
  localparam logic [2:0] OP_SET_TOS  = 3'd7;

  typedef enum logic [3:0] {
    IDLE, MEM_WAIT, MEM_RD, STK_RD, PUSH_LATCH,
    PUSH_WR, MEM_LATCH, MEM_WR, TOS_LOAD, SETTLE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] op_q;
  logic       err_q;
  logic       accept;
  logic       ovf_det, unf_det, err_det;

  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Pushes (DUP included) need room; DUP/POP/STORE need an entry.
  assign ovf_det = accept && (&tos_cur) && (cmd_op <= OP_DUP);
  assign unf_det = accept && (tos_cur == '0) &&
                   (cmd_op == OP_DUP || cmd_op == OP_POP ||
                    cmd_op == OP_STORE);
  assign err_det = ovf_det || unf_det;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      err_q    <= 1'b0;
      ovf_flag <= 1'b0;
      unf_flag <= 1'b0;
      op_count <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= cmd_op;
        err_q <= err_det;
      end
      // A new error wins over a simultaneous clear.
      if (ovf_det)      ovf_flag <= 1'b1;
      else if (err_clr) ovf_flag <= 1'b0;
      if (unf_det)      unf_flag <= 1'b1;
      else if (err_clr) unf_flag <= 1'b0;
      if (state_q == SETTLE && !err_q)
        op_count <= op_count + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (err_det) state_d = SETTLE;
          else begin
            unique case (cmd_op)
              OP_PUSH_ALU,
              OP_PUSH_RET,
              OP_PUSH_ARG: state_d = PUSH_LATCH;
              OP_LOAD:     state_d = MEM_WAIT;
              OP_DUP,
              OP_POP,
              OP_STORE:    state_d = STK_RD;
              OP_SET_TOS:  state_d = TOS_LOAD;
              default:     state_d = IDLE;
            endcase
          end
        end
      end
      MEM_WAIT:   state_d = MEM_RD;
      MEM_RD:     state_d = PUSH_LATCH;
      STK_RD: begin
        if (op_q == OP_DUP)        state_d = PUSH_LATCH;
        else if (op_q == OP_STORE) state_d = MEM_LATCH;
        else                       state_d = SETTLE;
      end
      PUSH_LATCH: state_d = PUSH_WR;
      PUSH_WR:    state_d = SETTLE;
      MEM_LATCH:  state_d = MEM_WR;
      MEM_WR:     state_d = SETTLE;
      TOS_LOAD:   state_d = SETTLE;
      SETTLE:     state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    SEL_MUX_STACK        = 3'b000;
    CTRL_REG_READ_STACK  = 1'b0;
    CTRL_REG_WRITE_STACK = 1'b0;
    CTRL_REG_READ_MEM    = 1'b0;
    CTRL_REG_WRITE_MEM   = 1'b0;
    SEL_MUX_TOS          = 1'b0;
    CTRL_REG_TOS         = 1'b0;
    SEL_TOS_UPDATER      = 1'b0;
    CTRL_STACK           = 1'b0;
    CTRL_MEM_EXT         = 1'b0;
    done                 = 1'b0;
    done_err             = 1'b0;
    unique case (state_q)
      MEM_RD: CTRL_REG_READ_MEM = 1'b1;
      STK_RD: begin
        CTRL_REG_READ_STACK = 1'b1;
        if (op_q == OP_POP || op_q == OP_STORE) begin
          CTRL_REG_TOS    = 1'b1;
          SEL_TOS_UPDATER = 1'b1;
        end
      end
      // Op encoding doubles as the stack write-data select.
      PUSH_LATCH: begin
        SEL_MUX_STACK        = op_q;
        CTRL_REG_WRITE_STACK = 1'b1;
        CTRL_REG_TOS         = 1'b1;
      end
      PUSH_WR: begin
        SEL_MUX_STACK = op_q;
        CTRL_STACK    = 1'b1;
      end
      MEM_LATCH: CTRL_REG_WRITE_MEM = 1'b1;
      MEM_WR:    CTRL_MEM_EXT       = 1'b1;
      TOS_LOAD: begin
        SEL_MUX_TOS  = 1'b1;
        CTRL_REG_TOS = 1'b1;
      end
      SETTLE: begin
        done     = 1'b1;
        done_err = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_tos_sequencer.sv
// Bench for stack_tos_sequencer: directed plan steps plus
// random commands against a per-op expected-strobe model.
module tb_stack_tos_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic        cmd_ready;
  logic [11:0] tos_cur;
  logic        err_clr;
  logic [2:0]  SEL_MUX_STACK;
  logic        CTRL_REG_READ_STACK, CTRL_REG_WRITE_STACK;
  logic        CTRL_REG_READ_MEM, CTRL_REG_WRITE_MEM;
  logic        SEL_MUX_TOS, CTRL_REG_TOS, SEL_TOS_UPDATER;
  logic        CTRL_STACK, CTRL_MEM_EXT;
  logic        done, done_err, ovf_flag, unf_flag;
  logic [15:0] op_count;

  always #5 clk = ~clk;

  stack_tos_sequencer #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .tos_cur(tos_cur),
    .err_clr(err_clr),
    .SEL_MUX_STACK(SEL_MUX_STACK),
    .CTRL_REG_READ_STACK(CTRL_REG_READ_STACK),
    .CTRL_REG_WRITE_STACK(CTRL_REG_WRITE_STACK),
    .CTRL_REG_READ_MEM(CTRL_REG_READ_MEM),
    .CTRL_REG_WRITE_MEM(CTRL_REG_WRITE_MEM),
    .SEL_MUX_TOS(SEL_MUX_TOS),
    .CTRL_REG_TOS(CTRL_REG_TOS),
    .SEL_TOS_UPDATER(SEL_TOS_UPDATER),
    .CTRL_STACK(CTRL_STACK),
    .CTRL_MEM_EXT(CTRL_MEM_EXT),
    .done(done), .done_err(done_err),
    .ovf_flag(ovf_flag), .unf_flag(unf_flag),
    .op_count(op_count)
  );

  // Strobe word: {sel[2:0], rd_stk, wr_stk, rd_mem, wr_mem,
  //               mux_tos, reg_tos, tos_dec, stk, mem_ext,
  //               done, done_err}
  localparam logic [13:0] RRS = 14'h400;
  localparam logic [13:0] RWS = 14'h200;
  localparam logic [13:0] RRM = 14'h100;
  localparam logic [13:0] RWM = 14'h080;
  localparam logic [13:0] SMT = 14'h040;
  localparam logic [13:0] CRT = 14'h020;
  localparam logic [13:0] STU = 14'h010;
  localparam logic [13:0] CS  = 14'h008;
  localparam logic [13:0] CME = 14'h004;
  localparam logic [13:0] DN  = 14'h002;
  localparam logic [13:0] DE  = 14'h001;

  int checks = 0;
  int failures = 0;
  logic        ovf_m, unf_m;
  logic [15:0] cnt_m;
  logic [13:0] exp_q[$];

  wire [13:0] obs = {SEL_MUX_STACK, CTRL_REG_READ_STACK,
    CTRL_REG_WRITE_STACK, CTRL_REG_READ_MEM,
    CTRL_REG_WRITE_MEM, SEL_MUX_TOS, CTRL_REG_TOS,
    SEL_TOS_UPDATER, CTRL_STACK, CTRL_MEM_EXT,
    done, done_err};

  task automatic check(input string tag,
                       input logic [31:0] o,
                       input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [13:0] latch(input logic [2:0] s);
    return {s, 11'h0} | RWS | CRT;
  endfunction

  function automatic logic [13:0] wr(input logic [2:0] s);
    return {s, 11'h0} | CS;
  endfunction

  // Expected per-cycle strobes after accept, from the op table.
  task automatic build(input logic [2:0] op, input logic err);
    exp_q.delete();
    if (!err) begin
      case (op)
        3'd0, 3'd2, 3'd3: begin
          exp_q.push_back(latch(op));
          exp_q.push_back(wr(op));
        end
        3'd1: begin
          exp_q.push_back(14'h0);
          exp_q.push_back(RRM);
          exp_q.push_back(latch(3'd1));
          exp_q.push_back(wr(3'd1));
        end
        3'd4: begin
          exp_q.push_back(RRS);
          exp_q.push_back(latch(3'd4));
          exp_q.push_back(wr(3'd4));
        end
        3'd5: exp_q.push_back(RRS | CRT | STU);
        3'd6: begin
          exp_q.push_back(RRS | CRT | STU);
          exp_q.push_back(RWM);
          exp_q.push_back(CME);
        end
        default: exp_q.push_back(SMT | CRT);
      endcase
    end
    exp_q.push_back(err ? (DN | DE) : DN);
  endtask

  // Entered and left on a negedge with the DUT idle.
  task automatic run_cmd(input logic [2:0] op,
                         input logic [11:0] tos,
                         input logic clr);
    logic ovf_s, unf_s, err;
    int n;
    check("ready_pre", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tos_cur   = tos;
    err_clr   = clr;
    ovf_s = (tos == 12'hFFF) && (op <= 3'd4);
    unf_s = (tos == 12'h000) && (op >= 3'd4) && (op <= 3'd6);
    err   = ovf_s | unf_s;
    build(op, err);
    n = exp_q.size();
    @(posedge clk);
    ovf_m = ovf_s | (ovf_m & ~clr);
    unf_m = unf_s | (unf_m & ~clr);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) begin
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        cmd_op    = 3'($urandom_range(0, 7));
      end
      check($sformatf("op%0d_tos%0h_c%0d", op, tos, k + 1),
            obs, exp_q[k]);
      check($sformatf("busy_op%0d_c%0d", op, k + 1),
            cmd_ready, 0);
      check($sformatf("ovf_op%0d_c%0d", op, k + 1),
            ovf_flag, ovf_m);
      check($sformatf("unf_op%0d_c%0d", op, k + 1),
            unf_flag, unf_m);
    end
    if (!err) cnt_m = cnt_m + 16'd1;
    @(negedge clk);
    check("ready_post", cmd_ready, 1);
    check("idle_strobes", obs, 0);
    check("op_count", op_count, cnt_m);
    check("ovf_flag", ovf_flag, ovf_m);
    check("unf_flag", unf_flag, unf_m);
  endtask

  function automatic logic [11:0] pick_tos();
    case ($urandom_range(0, 4))
      0: return 12'h000;
      1: return 12'hFFF;
      2: return 12'h001;
      3: return 12'hFFE;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    tos_cur   = 12'h0;
    err_clr   = 1'b0;
    ovf_m = 1'b0; unf_m = 1'b0; cnt_m = 16'd0;
    #12;
    check("rst_strobes", obs, 0);
    check("rst_count", op_count, 0);
    check("rst_flags", {ovf_flag, unf_flag}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);

    // Idle with no valid: nothing accepted.
    for (int i = 0; i < 3; i++) begin
      cmd_op = 3'($urandom_range(0, 7));
      @(negedge clk);
      check("idle_noacc", {cmd_ready, obs}, {1'b1, 14'h0});
    end

    run_cmd(3'd3, 12'h000, 1'b0);
    run_cmd(3'd1, 12'h005, 1'b0);
    run_cmd(3'd6, 12'h003, 1'b0);
    run_cmd(3'd5, 12'h000, 1'b0);
    run_cmd(3'd6, 12'h000, 1'b1);
    run_cmd(3'd4, 12'hFFF, 1'b0);
    run_cmd(3'd7, 12'h010, 1'b1);
    run_cmd(3'd4, 12'h000, 1'b0);
    run_cmd(3'd0, 12'hFFF, 1'b0);

    for (int i = 0; i < 300; i++)
      run_cmd(3'($urandom_range(0, 7)), pick_tos(),
              ($urandom_range(0, 3) == 0));

    // Make sure flags and count are nonzero before reset.
    run_cmd(3'd5, 12'h000, 1'b0);
    run_cmd(3'd2, 12'hFFF, 1'b0);
    run_cmd(3'd2, 12'h020, 1'b0);

    // Reset in the PUSH_WR cycle of a PUSH_ALU.
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    tos_cur   = 12'h007;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_latch", obs, latch(3'd0));
    @(negedge clk);
    check("mid_wr", obs, wr(3'd0));
    #2 reset = 1'b0;
    #1;
    check("async_strobes", obs, 0);
    check("async_flags", {ovf_flag, unf_flag}, 0);
    check("async_count", op_count, 0);
    ovf_m = 1'b0; unf_m = 1'b0; cnt_m = 16'd0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_strobes", obs, 0);
    run_cmd(3'd7, 12'h100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
